// File: rtl/demux1to8_result_bank_if.sv
// Result-bank bus: producer write handshake plus consumer read port.
//   in_valid/in_ready/f2/f1/f0/din : write side (code {f2,f1,f0} picks the slot)
//   rd_en/rd_sel                   : read request, single-cycle strobe
//   dout/dout_valid/rd_err         : registered read response
//   slot_full/accept_count         : occupancy flags and accepted-write counter
interface demux1to8_result_bank_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             f2;
   logic             f1;
   logic             f0;
   logic [WIDTH-1:0] din;
   logic             rd_en;
   logic [2:0]       rd_sel;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             rd_err;
   logic [7:0]       slot_full;
   logic [CNT_W-1:0] accept_count;

   // Producer/consumer side
   modport master (
      output in_valid, f2, f1, f0, din, rd_en, rd_sel,
      input  in_ready, dout, dout_valid, rd_err, slot_full, accept_count
   );

   // Result bank side
   modport slave (
      input  in_valid, f2, f1, f0, din, rd_en, rd_sel,
      output in_ready, dout, dout_valid, rd_err, slot_full, accept_count
   );
endinterface

// File: rtl/demux1to8_result_bank.sv
// Eight-slot result bank: steers an ALU result word into the slot named by its
// {f2,f1,f0} function code, and lets a consumer drain slots by index.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - demux1to8_result_bank_if slave modport (write handshake, read port,
//         occupancy flags, accepted-write counter)
module demux1to8_result_bank #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic                         clk,
   input logic                         rst,
   demux1to8_result_bank_if.slave      bus
);
   localparam int unsigned NSLOT = 8;
   localparam int unsigned SEL_W = 3;

   logic [WIDTH-1:0] slot_q [NSLOT];
   logic [WIDTH-1:0] slot_d [NSLOT];
   logic [NSLOT-1:0] full_q, full_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             rd_err_q, rd_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SEL_W-1:0] sel;
   logic             in_ready_c;
   logic             wr_fire;
   logic             rd_hit;

   assign sel = {bus.f2, bus.f1, bus.f0};

   // An occupied slot may still accept when the same edge drains it
   assign in_ready_c = !full_q[sel] || (bus.rd_en && (bus.rd_sel == sel) && full_q[sel]);
   assign wr_fire    = bus.in_valid && in_ready_c;
   assign rd_hit     = bus.rd_en && full_q[bus.rd_sel];

   // Next-state: read clears before write sets, so a same-slot write keeps the flag high
   always_comb begin
      slot_d       = slot_q;
      full_d       = full_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      rd_err_d     = 1'b0;
      cnt_d        = cnt_q;

      if (bus.rd_en) begin
         if (rd_hit) begin
            dout_d               = slot_q[bus.rd_sel];
            dout_valid_d         = 1'b1;
            full_d[bus.rd_sel]   = 1'b0;
         end else begin
            rd_err_d = 1'b1;
         end
      end

      if (wr_fire) begin
         slot_d[sel] = bus.din;
         full_d[sel] = 1'b1;
         cnt_d       = cnt_q + CNT_W'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q       <= '{default: '0};
         full_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         rd_err_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         slot_q       <= slot_d;
         full_q       <= full_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         rd_err_q     <= rd_err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.in_ready     = in_ready_c;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.rd_err       = rd_err_q;
   assign bus.slot_full    = full_q;
   assign bus.accept_count = cnt_q;
endmodule

// File: tb/tb_demux1to8_result_bank.sv
// Directed bench for demux1to8_result_bank; read responses go through a scoreboard queue.
module tb_demux1to8_result_bank;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 8;

   typedef struct packed {
      logic             err;
      logic [WIDTH-1:0] data;
   } resp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   resp_t exp_q [$];

   demux1to8_result_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   demux1to8_result_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_code(input int c);
      logic [2:0] v;
      v = 3'(c);
      bus.f2 = v[2];
      bus.f1 = v[1];
      bus.f0 = v[0];
   endtask

   task automatic push(input logic err, input logic [WIDTH-1:0] data);
      resp_t r;
      r.err  = err;
      r.data = data;
      exp_q.push_back(r);
   endtask

   // Monitor: every response pulse must match the next expected entry
   always @(negedge clk) begin
      if (!rst && (bus.dout_valid || bus.rd_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: dout_valid=%0b rd_err=%0b dout=%0h, none expected at %0t",
                     bus.dout_valid, bus.rd_err, bus.dout, $time);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("resp_dout_valid", 32'(bus.dout_valid), 32'(!e.err));
            check("resp_rd_err", 32'(bus.rd_err), 32'(e.err));
            check("resp_dout", 32'(bus.dout), 32'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      set_code(0);
      bus.din = '0;
      bus.rd_en = 1'b0;
      bus.rd_sel = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // 1: post-reset idle state
      check("rst_slot_full", 32'(bus.slot_full), 32'h00);
      check("rst_accept_count", 32'(bus.accept_count), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      check("rst_rd_err", 32'(bus.rd_err), 32'd0);
      for (int c = 0; c < 8; c++) begin
         set_code(c);
         #1;
         check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      end

      // 2: steer every code, then drain back-to-back
      step();
      for (int c = 0; c < 8; c++) begin
         bus.in_valid = 1'b1;
         set_code(c);
         bus.din = WIDTH'(c + 1);
         #1;
         check("steer_in_ready", 32'(bus.in_ready), 32'd1);
         step();
      end
      bus.in_valid = 1'b0;
      check("steer_slot_full", 32'(bus.slot_full), 32'hFF);
      check("steer_accept_count", 32'(bus.accept_count), 32'd8);
      for (int r = 0; r < 8; r++) begin
         bus.rd_en = 1'b1;
         bus.rd_sel = 3'(r);
         push(1'b0, WIDTH'(r + 1));
         step();
      end
      bus.rd_en = 1'b0;
      check("drain_slot_full", 32'(bus.slot_full), 32'h00);
      step();

      // 3: backpressure on an occupied slot
      bus.in_valid = 1'b1;
      set_code(3);
      bus.din = 4'hA;
      step();
      bus.din = 4'h5;
      #1;
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      step();
      check("bp_slot3_full", 32'(bus.slot_full), 32'h08);
      check("bp_accept_count_held", 32'(bus.accept_count), 32'd9);
      bus.rd_en = 1'b1;
      bus.rd_sel = 3'd3;
      #1;
      check("bp_in_ready_on_read", 32'(bus.in_ready), 32'd1);
      push(1'b0, 4'hA);
      step();
      bus.in_valid = 1'b0;
      check("bp_refilled", 32'(bus.slot_full), 32'h08);
      check("bp_accept_count", 32'(bus.accept_count), 32'd10);
      push(1'b0, 4'h5);
      step();
      bus.rd_en = 1'b0;
      check("bp_drained", 32'(bus.slot_full), 32'h00);

      // 4: same-cycle read and write of slot 6
      bus.in_valid = 1'b1;
      set_code(6);
      bus.din = 4'h2;
      step();
      bus.din = 4'h9;
      bus.rd_en = 1'b1;
      bus.rd_sel = 3'd6;
      push(1'b0, 4'h2);
      step();
      bus.in_valid = 1'b0;
      check("rw6_slot_full", 32'(bus.slot_full), 32'h40);
      check("rw6_accept_count", 32'(bus.accept_count), 32'd12);
      push(1'b0, 4'h9);
      step();
      bus.rd_en = 1'b0;
      check("rw6_drained", 32'(bus.slot_full), 32'h00);
      step();

      // 5: empty-slot read keeps dout at its last value
      bus.rd_en = 1'b1;
      bus.rd_sel = 3'd5;
      push(1'b1, 4'h9);
      step();
      bus.rd_en = 1'b0;
      step();
      check("empty_dout_after", 32'(bus.dout), 32'h9);

      // 6: counter wrap from a clean start
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("wrap_start", 32'(bus.accept_count), 32'd0);
      set_code(0);
      for (int i = 0; i < 256; i++) begin
         bus.in_valid = 1'b1;
         bus.din = WIDTH'(i);
         step();
         bus.in_valid = 1'b0;
         bus.rd_en = 1'b1;
         bus.rd_sel = 3'd0;
         push(1'b0, WIDTH'(i));
         step();
         bus.rd_en = 1'b0;
      end
      check("wrap_accept_count", 32'(bus.accept_count), 32'd0);

      // Reset mid-cycle while a write is pending on a full slot 0
      bus.in_valid = 1'b1;
      bus.din = 4'h7;
      step();
      check("pre_rst_full", 32'(bus.slot_full), 32'h01);
      #2;
      rst = 1'b1;
      #1;
      check("async_slot_full", 32'(bus.slot_full), 32'h00);
      check("async_accept_count", 32'(bus.accept_count), 32'd0);
      check("async_dout", 32'(bus.dout), 32'd0);
      check("async_dout_valid", 32'(bus.dout_valid), 32'd0);
      check("async_rd_err", 32'(bus.rd_err), 32'd0);
      step();
      bus.in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("post_rst_full", 32'(bus.slot_full), 32'h00);
      bus.rd_en = 1'b1;
      bus.rd_sel = 3'd0;
      push(1'b1, 4'h0);
      step();
      bus.rd_en = 1'b0;
      repeat (3) step();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux1to8_result_bank.md
Name: demux1to8_result_bank

Overview:
- Receiving end of the ALU function-select path: where the 8:1 select network picks one of eight function results using f2/f1/f0, this block takes one result word plus its f2/f1/f0 code and steers it into one of eight holding slots.
- A downstream consumer drains each slot by index.
- Valid/ready handshake on the write side; registered read port with per-slot occupancy flags.
- Sits after the ALU result bus, ahead of register writeback.

Parameters:
WIDTH, 4, width of the result word (matches the 4-bit ALU datapath)
CNT_W, 8, width of the accepted-write counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer presents a result
in_ready  output  1  block can accept into the addressed slot
f2  input  1  function code MSB (slot index bit 2)
f1  input  1  function code bit 1
f0  input  1  function code LSB
din  input  WIDTH  result word
rd_en  input  1  consumer read request, single-cycle strobe
rd_sel  input  3  slot index to read
dout  output  WIDTH  read data, registered
dout_valid  output  1  one-cycle pulse: dout is fresh
rd_err  output  1  one-cycle pulse: read of an empty slot
slot_full  output  8  occupancy flag per slot
accept_count  output  CNT_W  number of accepted writes, wraps

Behaviour:
- Reset (rst=1, asynchronous, any time): all slot data, slot_full, dout, dout_valid, rd_err and accept_count go to 0 immediately. Reset mid-handshake discards pending data; no partial write survives.
- Slot index: sel = {f2,f1,f0}. Code 3'b000 maps to slot 0, 3'b111 maps to slot 7.
- in_ready is combinational: in_ready = !slot_full[sel] OR (rd_en AND rd_sel==sel AND slot_full[sel]). It does not depend on in_valid.
- Write fires when in_valid AND in_ready at a rising edge:
  - slot[sel] <= din, slot_full[sel] <= 1, accept_count increments.
  - accept_count wraps from 2^CNT_W-1 to 0.
- Producer rule: hold din and f2/f1/f0 stable while in_valid=1 and in_ready=0. The block never drops or overwrites an occupied slot.
- Read, decided at a rising edge with rd_en=1:
  - If slot_full[rd_sel]=1: the next cycle has dout = slot[rd_sel] and dout_valid=1 for exactly one cycle; slot_full[rd_sel] clears at the same edge.
  - If slot_full[rd_sel]=0: the next cycle has rd_err=1 for one cycle, dout_valid=0, and dout holds its previous value.
- Read latency: 1 cycle, with back-to-back reads allowed every cycle.
- Simultaneous write and read of the same full slot:
  - The read returns the old data.
  - The new data is stored and slot_full stays 1.
  - accept_count increments.
- Simultaneous write and read of the same empty slot:
  - The read reports rd_err and does not forward the new data.
  - The write completes and slot_full becomes 1.
- Simultaneous write and read of different slots: fully independent.
- Outside read-response cycles, dout_valid=0 and rd_err=0. dout holds its last value.
- Fully synchronous to clk apart from the asynchronous reset assertion. No other state machine: state is the 8 slots, 8 flags, output registers and the counter.

Test Plan:
1. Reset then idle:
   - Assert rst mid-cycle: all outputs go to 0 asynchronously.
   - After release: slot_full=8'h00, in_ready=1 for every code, accept_count=0.
2. Steer all codes:
   - Write din=code+1 with f2f1f0=0..7 on consecutive cycles: slot_full=8'hFF, accept_count=8.
   - Read rd_sel=0..7 back-to-back: dout=1..8 with dout_valid high on 8 consecutive cycles; slot_full=8'h00 at the end.
3. Backpressure:
   - Fill slot 3 with 4'hA, then present din=4'h5 at code 3: in_ready=0 and slot 3 keeps 4'hA.
   - Read slot 3: dout=4'hA.
   - Pending write then accepted the same cycle (in_ready=1 during the read); a following read returns 4'h5.
4. Same-cycle read and write of slot 6:
   - Slot 6 holds 4'h2; read slot 6 while writing 4'h9 to code 6.
   - Required: dout=4'h2 with dout_valid=1, slot_full[6] stays 1, a next read returns 4'h9.
5. Empty read:
   - rd_en with rd_sel=5 on an empty slot: rd_err pulses 1 cycle, dout_valid=0, dout unchanged.
6. Counter wrap and reset mid-operation:
   - 256 write/read pairs on slot 0: accept_count returns to 0.
   - Assert rst while in_valid=1 and slot 0 is full: slot_full=0, and no dout_valid pulse follows.
